// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold/flush sequencer.
// - Hold codes: a stage register holds when hold_code >= its own stage code.
// - Hold enable/disable levels, the NOP word loaded on flush, FSM encoding.
// - stage_wr_en(): write-enable helper for stage registers.
package pipe_hold_ctrl_pkg;

  // Default width of hold_code; pipe_hold_ctrl exposes it as parameter HC_W.
  localparam int unsigned HOLD_CODE_W = 3;

  typedef logic [HOLD_CODE_W-1:0] hc_t;

  localparam hc_t HOLD_CODE_NONE = 3'd0;
  localparam hc_t HOLD_CODE_PC   = 3'd1;
  localparam hc_t HOLD_CODE_IF   = 3'd2;
  localparam hc_t HOLD_CODE_ID   = 3'd3;
  localparam hc_t HOLD_CODE_EX   = 3'd4;
  localparam hc_t HOLD_CODE_MEM  = 3'd5;

  localparam logic HOLD_EN  = 1'b1;
  localparam logic HOLD_DIS = 1'b0;

  // Instruction word a flushed IF/ID or ID/EX register loads (NOP).
  localparam logic [31:0] ZERO_WORD = '0;

  // Explicit encoding keeps state values identical to the legacy netlist.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV_WAIT = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // A stage register loads only while hold_code is below its own code.
  // Its clear (own flush strobe) takes priority over this enable.
  function automatic logic stage_wr_en(input hc_t hold_code, input hc_t stage_code);
    return (hold_code < stage_code) ? HOLD_EN : HOLD_DIS;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_wait_timer.sv
// pipe_wait_timer: MEM bus-wait watchdog.
// Counts cycles spent in MEM_WAIT and flags a timeout on the cycle the count
// reaches TO_CYC-1 without a grant. A grant in that same cycle wins.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   run_i      - FSM is in MEM_WAIT this cycle
//   gnt_i      - bus access completed this cycle
//   timeout_o  - combinational: this MEM_WAIT cycle is the timeout cycle
module pipe_wait_timer #(
  parameter int unsigned TO_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic gnt_i,
  output logic timeout_o
);

  localparam int unsigned CW = $clog2(TO_CYC);
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;

  always_comb begin
    timeout = run_i && !gnt_i && (cnt_q == LAST);
    // Counter only lives inside an uninterrupted wait; any exit clears it.
    cnt_d = '0;
    if (run_i && !gnt_i && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = timeout;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: central hold/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   ld_use_i      - ID load-use hazard
//   div_start_i   - EX divide issued (pulse)
//   div_done_i    - EX divide result valid (pulse)
//   mem_req_i     - MEM data access requested
//   mem_gnt_i     - bus access completed this cycle
//   jump_i        - EX taken branch/jump
//   hold_code_o   - NONE=0 PC=1 IF=2 ID=3 EX=4 MEM=5 (combinational)
//   flush_ifid_o  - clear IF/ID to NOP
//   flush_idex_o  - clear ID/EX to NOP
//   bus_to_o      - 1-cycle pulse on MEM wait timeout
//   stall_cnt_o   - saturating count of cycles with hold_code_o != NONE
module pipe_hold_ctrl #(
  parameter int unsigned HC_W   = 3,
  parameter int unsigned TO_CYC = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_use_i,
  input  logic             div_start_i,
  input  logic             div_done_i,
  input  logic             mem_req_i,
  input  logic             mem_gnt_i,
  input  logic             jump_i,
  output logic [HC_W-1:0]  hold_code_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             bus_to_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  import pipe_hold_ctrl_pkg::*;

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  hc_t              hold_base;
  hc_t              hold_code;
  logic             jump_any;
  logic             flush;
  logic             timeout;
  logic             mem_wait;

  assign mem_wait = (state_q == ST_MEM_WAIT);

  pipe_wait_timer #(
    .TO_CYC (TO_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .run_i     (mem_wait),
    .gnt_i     (mem_gnt_i),
    .timeout_o (timeout)
  );

  always_comb begin
    // Hold from the multi-cycle causes only; ld_use is folded in later
    // because a flush squashes the hazarding instruction.
    hold_base = HOLD_CODE_NONE;
    if ((mem_wait && !mem_gnt_i) ||
        (state_q == ST_IDLE && mem_req_i && !mem_gnt_i)) begin
      hold_base = HOLD_CODE_MEM;
    end else if ((state_q == ST_DIV_WAIT && !div_done_i) ||
                 (state_q == ST_IDLE && div_start_i)) begin
      hold_base = HOLD_CODE_EX;
    end

    // A jump (new or deferred) issues only while nothing at EX or above holds.
    jump_any = jump_i || pend_q;
    flush    = !rst && jump_any && (hold_base < HOLD_CODE_EX);
    pend_d   = jump_any && !flush;

    hold_code = HOLD_CODE_NONE;
    if (!rst) begin
      if (hold_base != HOLD_CODE_NONE) begin
        hold_code = hold_base;
      end else if (ld_use_i && !flush) begin
        hold_code = HOLD_CODE_ID;
      end
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_i && !mem_gnt_i) begin
          state_d = ST_MEM_WAIT;
        end else if (div_start_i) begin
          state_d = ST_DIV_WAIT;
        end
      end
      ST_DIV_WAIT: begin
        if (div_done_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_gnt_i || timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (hold_code != HOLD_CODE_NONE && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hold_code_o  = HC_W'(hold_code);
  assign flush_ifid_o = flush;
  assign flush_idex_o = flush;
  assign bus_to_o     = timeout && !rst;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
